// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, defaults
// and the offset-to-register decode helper.
package int_ctrl_pkg;

    localparam int          NSRC_MAX = 6;
    localparam logic [31:0] DEF_BASE = 32'h0000_7F40;

    localparam logic [3:0] OFF_PEND = 4'h0;
    localparam logic [3:0] OFF_MASK = 4'h4;
    localparam logic [3:0] OFF_EDGE = 4'h8;
    localparam logic [3:0] OFF_CLR  = 4'hC;

    typedef enum logic [1:0] {
        REG_PEND,
        REG_MASK,
        REG_EDGE,
        REG_CLR
    } reg_sel_e;

    function automatic reg_sel_e reg_sel(input logic [3:0] off);
        reg_sel_e sel;
        case (off)
            OFF_MASK: sel = REG_MASK;
            OFF_EDGE: sel = REG_EDGE;
            OFF_CLR:  sel = REG_CLR;
            default:  sel = REG_PEND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Highest-index-wins priority encoder over the masked pending vector.
// Purely combinational; the top registers its outputs alongside HWInt.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [NSRC_MAX-1:0] vec_i,
    output logic [2:0]          id_o,
    output logic                valid_o
);

    always_comb begin
        id_o = 3'd0;
        priority case (1'b1)
            vec_i[5]: id_o = 3'd5;
            vec_i[4]: id_o = 3'd4;
            vec_i[3]: id_o = 3'd3;
            vec_i[2]: id_o = 3'd2;
            vec_i[1]: id_o = 3'd1;
            vec_i[0]: id_o = 3'd0;
            default:  id_o = 3'd0;
        endcase
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches timer/pin requests, applies mask and
// edge/level mode, and presents a registered HWInt vector plus source ID.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NSRC     = 6,
    parameter logic [31:0] BASE     = DEF_BASE,
    parameter logic [5:0]  DEF_EDGE = 6'b000100
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic [31:0]     b_adress,
    input  logic            b_we,
    input  logic [3:0]      b_byteen,
    input  logic [31:0]     b_Wdata,
    output logic [31:0]     b_Rdata,
    output logic            hit,
    output logic [5:0]      HWInt,
    output logic            irq_valid,
    output logic [2:0]      irq_id
);

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic [NSRC-1:0] prev_q;
    logic [5:0]      hwint_q;
    logic [2:0]      id_q;
    logic            valid_q;

    logic [31:0]     off_full;
    logic [3:0]      off_w;
    reg_sel_e        sel;
    logic            wr;
    logic [NSRC-1:0] wdata;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] mode_chg;
    logic [NSRC_MAX-1:0] act_vec;
    logic [2:0]      enc_id;
    logic            enc_valid;
    logic            unused_wdata;

    assign off_full = b_adress - BASE;
    assign hit      = (b_adress >= BASE) && (off_full < 32'd16);
    assign off_w    = {off_full[3:2], 2'b00};
    assign sel      = reg_sel(off_w);
    assign wr       = hit && b_we && (b_byteen == 4'hF);
    assign wdata    = b_Wdata[NSRC-1:0];

    generate
        if (NSRC < 32) begin : g_unused
            assign unused_wdata = ^b_Wdata[31:NSRC];
        end else begin : g_full
            assign unused_wdata = 1'b0;
        end
    endgenerate

    always_comb begin
        rise     = src_irq & ~prev_q;
        clr      = '0;
        mask_d   = mask_q;
        edge_d   = edge_q;
        mode_chg = '0;
        if (wr && sel == REG_CLR) begin
            clr = wdata;
        end
        if (wr && sel == REG_MASK) begin
            mask_d = wdata;
        end
        if (wr && sel == REG_EDGE) begin
            edge_d   = wdata;
            mode_chg = edge_q ^ wdata;
        end
        // A rise beats a same-cycle W1C so no edge event is dropped.
        pend_d = (edge_q & (rise | (pend_q & ~clr)))
               | (~edge_q & src_irq);
        pend_d = pend_d & ~mode_chg;
    end

    always_comb begin
        act_vec            = '0;
        act_vec[NSRC-1:0]  = pend_q & mask_q;
    end

    int_prio_enc u_enc (
        .vec_i   (act_vec),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            edge_q  <= DEF_EDGE[NSRC-1:0];
            prev_q  <= '0;
            hwint_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            prev_q  <= src_irq;
            hwint_q <= act_vec;
            id_q    <= enc_id;
            valid_q <= enc_valid;
        end
    end

    always_comb begin
        b_Rdata = '0;
        if (hit) begin
            case (sel)
                REG_PEND: b_Rdata = 32'(pend_q);
                REG_MASK: b_Rdata = 32'(mask_q);
                REG_EDGE: b_Rdata = 32'(edge_q);
                default:  b_Rdata = '0;
            endcase
        end
    end

    assign HWInt     = hwint_q;
    assign irq_valid = valid_q;
    assign irq_id    = id_q;

endmodule
